// File: rtl/uart_recv_sink.sv
// 8N1 UART receiver with mid-bit sampling, byte strobe and error flags.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_recv_sink #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic       enable,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam logic [15:0] CNT_HALF = 16'(BAUD_CNT / 2 - 1);
  localparam logic [15:0] CNT_LAST = 16'(BAUD_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic        en_q, en_d;
  logic        fe_q, fe_d;
  logic        rx_m_q, rx_s_q, rx_p_q;
  logic        fall;

`ifdef UART_RX_PARITY_EN
  logic        pend_q, pend_d;
  logic        pe_q, pe_d;
`endif

  assign fall = rx_p_q & ~rx_s_q;

  // two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // receive state machine: next state, counters and strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pend_d  = pend_q;
    pe_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = 16'd0;
`ifdef UART_RX_PARITY_EN
          pend_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = 16'd0;
          idx_d = 3'd0;
          if (!rx_s_q) state_d = DATA;
          else         state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 16'd0;
          pend_d  = (^shift_q) ^ rx_s_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          if (!rx_s_q) begin
            fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (pend_q) begin
            pe_d = 1'b1;
`endif
          end else begin
            dout_d = shift_q;
            en_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // state, datapath and strobe registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
      en_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      fe_q    <= fe_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // pending parity error and its strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      pe_q   <= pe_d;
    end
  end

  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign enable    = en_q;
  assign frame_err = fe_q;
  assign dout      = dout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv_sink.sv
// Scoreboard bench for uart_recv_sink at 16 clocks per bit.
// Expected strobes are queued by stimulus and popped by a monitor.
module tb_uart_recv_sink;

  localparam int BC = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       enable;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_recv_sink #(
    .CLK_FREQ(1600),
    .BAUD    (100)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .enable    (enable),
    .dout      (dout),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BC);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    tick(BC);
`endif
    rx = stop;
    tick(BC);
    rx = 1'b1;
  endtask

  // monitor: compare every strobe against the head of the queue
  always @(negedge sys_clk) begin
    if (sys_rst_n && (enable || frame_err || parity_err)) begin
      logic [1:0] ak;
      exp_t e;
      ak = enable ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
      chk("strobe_onehot", $countones({enable, frame_err, parity_err}), 1);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: en=%b fe=%b pe=%b dout=%h, none expected",
                 enable, frame_err, parity_err, dout);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'(ak), 32'(e.kind));
        chk("strobe_dout", 32'(dout), 32'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] b77;
    b77 = 8'h77;
    tick(3);
    @(negedge sys_clk);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_busy", 32'(busy), 0);
    tick(1);
    sys_rst_n = 1'b1;
    tick(10);
    chk("idle_busy", 32'(busy), 0);

    push(2'd0, 8'hA5);
    send(8'hA5, 1'b1);
    tick(2);
    chk("a5_busy_fall", 32'(busy), 0);
    tick(20);

    push(2'd0, 8'h00);
    push(2'd0, 8'hFF);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(20);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    for (int k = 0; k < 10 && !busy; k++) tick(1);
    chk("glitch_busy_rise", 32'(busy), 1);
    for (int k = 0; k < 8 && busy; k++) tick(1);
    chk("glitch_busy_fall", 32'(busy), 0);
    tick(20);

    push(2'd1, 8'hFF);
    send(8'h3C, 1'b0);
    tick(20);
    chk("fe_dout_hold", 32'(dout), 32'hFF);

    push(2'd0, 8'hA5);
    send(8'hA5, 1'b1);
    tick(20);
    push(2'd1, 8'hA5);
    send(8'h3C, 1'b0);
    tick(20);

    rx = 1'b0;
    tick(BC);
    for (int i = 0; i < 4; i++) begin
      rx = b77[i];
      tick(BC);
    end
    rx = b77[4];
    tick(8);
    sys_rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_dout", 32'(dout), 0);
    sys_rst_n = 1'b1;
    tick(20);
    push(2'd0, 8'h5A);
    send(8'h5A, 1'b1);
    tick(20);

`ifdef UART_RX_PARITY_EN
    push(2'd2, 8'h5A);
    bad_par = 1'b1;
    send(8'h01, 1'b1);
    bad_par = 1'b0;
    tick(20);
`endif

    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
